// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the decode/issue path.
// Holds the issue-controller state encoding and the major-opcode constants
// used by decode.
// is_serial_op() shows how decode derives dec_serial: MISCMEM (FENCE) and
// SYSTEM must issue into an empty pipeline.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  function automatic logic is_serial_op(input logic [6:0] opcode);
    return (opcode == OPC_MISCMEM) || (opcode == OPC_SYSTEM);
  endfunction

endpackage

// File: rtl/sb_bitmap.sv
// sb_bitmap: 32-entry pending-write bitmap with hazard lookup.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   wb_en, wb_rd          writeback this cycle; clears the entry
//   set_en, set_rd        issued writer this cycle; sets the entry
//   rs1en/rs1, rs2en/rs2,
//   rden/rd               operands of the instruction in decode
//   pending               registered bitmap; bit 0 is always 0
//   wb_hit                a writeback to a real register (not x0) is happening
//   haz                   an enabled operand hits a pending entry
module sb_bitmap
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic        set_en,
  input  logic [4:0]  set_rd,
  input  logic        rs1en,
  input  logic [4:0]  rs1,
  input  logic        rs2en,
  input  logic [4:0]  rs2,
  input  logic        rden,
  input  logic [4:0]  rd,
  output logic [31:0] pending,
  output logic        wb_hit,
  output logic        haz
);

  logic [31:0] pending_reg;
  logic [31:0] wbm;
  logic [31:0] eff;
  logic [31:0] set_mask;

  assign wbm    = (wb_en && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;
  assign wb_hit = (wbm != 32'd0);

  // A writeback landing this cycle already resolves the hazard.
  assign eff = pending_reg & ~wbm;

  // Bit 0 never sets, so x0 never becomes pending.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_set
      if (gi == 0) begin : g_x0
        assign set_mask[gi] = 1'b0;
      end else begin : g_xn
        assign set_mask[gi] = set_en && (set_rd == 5'(gi));
      end
    end
  endgenerate

  // Set is OR-ed in after the clear, so an issue and a writeback to the same
  // register in one cycle leave the entry pending for the new writer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg <= 32'd0;
    end else begin
      pending_reg <= eff | set_mask;
    end
  end

  assign haz = (rs1en && (rs1 != 5'd0) && eff[rs1]) ||
               (rs2en && (rs2 != 5'd0) && eff[rs2]) ||
               (rden  && (rd  != 5'd0) && eff[rd]);

  assign pending = pending_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order issue controller between decode and execute.
// Stalls on RAW/WAW hazards and on the outstanding-writer limit, sequences a
// fixed-length flush after a redirect, and drains the pipeline before
// serializing (FENCE/SYSTEM) instructions.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   dec_*                      registered decode outputs
//   redirect                   one-cycle taken-branch/jump pulse from execute
//   wb_en, wb_rd               writeback this cycle
//   issue, stall               combinational issue handshake
//   flush                      registered squash of fetch/decode
//   sb_pending, out_cnt        registered scoreboard bitmap and writer count
module hazard_scoreboard
  import riscv_ctrl_pkg::*;
#(
  parameter int MAX_OUT      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic        dec_rs1en,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs2en,
  input  logic [4:0]  dec_rd,
  input  logic        dec_rden,
  input  logic        dec_serial,
  input  logic        redirect,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  output logic        issue,
  output logic        stall,
  output logic        flush,
  output logic [31:0] sb_pending,
  output logic [3:0]  out_cnt
);

  ctrl_state_t state_reg;
  logic [2:0]  flush_cnt_reg;
  logic        flush_reg;
  logic [3:0]  out_cnt_reg;

  logic        haz;
  logic        wb_hit;
  logic [3:0]  cnt_eff;
  logic        cap_ok;
  logic        serial_blocked;
  logic        issue_int;
  logic        writer_issued;

  sb_bitmap u_sb_bitmap (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .set_en  (writer_issued),
    .set_rd  (dec_rd),
    .rs1en   (dec_rs1en),
    .rs1     (dec_rs1),
    .rs2en   (dec_rs2en),
    .rs2     (dec_rs2),
    .rden    (dec_rden),
    .rd      (dec_rd),
    .pending (sb_pending),
    .wb_hit  (wb_hit),
    .haz     (haz)
  );

  // Writer count as seen after this cycle's writeback; floors at zero so a
  // stray writeback cannot wrap the count.
  assign cnt_eff = (wb_hit && (out_cnt_reg != 4'd0)) ? (out_cnt_reg - 4'd1) : out_cnt_reg;

  assign cap_ok         = (cnt_eff < 4'(MAX_OUT));
  assign serial_blocked = dec_serial && (cnt_eff != 4'd0);

  // reset gates both handshake outputs so nothing issues while reset is held.
  assign issue_int = reset && dec_valid && (state_reg == RUN) && !redirect &&
                     !haz && cap_ok && !serial_blocked;
  assign stall     = reset && dec_valid && !issue_int && !redirect && (state_reg != FLUSH);
  assign issue     = issue_int;

  assign writer_issued = issue_int && dec_rden && (dec_rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt_reg <= 4'd0;
    end else if (writer_issued && !wb_hit) begin
      out_cnt_reg <= out_cnt_reg + 4'd1;
    end else if (!writer_issued && wb_hit && (out_cnt_reg != 4'd0)) begin
      out_cnt_reg <= out_cnt_reg - 4'd1;
    end
  end

  // Redirect outranks every other event, including a pending drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      flush_cnt_reg <= 3'd0;
      flush_reg     <= 1'b0;
    end else if (redirect) begin
      state_reg     <= FLUSH;
      flush_cnt_reg <= 3'(FLUSH_CYCLES);
      flush_reg     <= 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (dec_valid && dec_serial && (cnt_eff != 4'd0)) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Leaves on the registered zero; the serial op issues next cycle.
          if (out_cnt_reg == 4'd0) begin
            state_reg <= RUN;
          end
        end
        FLUSH: begin
          if (flush_cnt_reg <= 3'd1) begin
            state_reg     <= RUN;
            flush_cnt_reg <= 3'd0;
            flush_reg     <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 3'd1;
          end
        end
        default: begin
          state_reg <= RUN;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  assign flush   = flush_reg;
  assign out_cnt = out_cnt_reg;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
In-order issue controller placed between DECODE's registered outputs and the execute/writeback stages.
- Tracks in-flight destination registers in a 32-entry scoreboard.
- Stalls decode on RAW/WAW hazards and on the outstanding-writer limit.
- On a taken-branch/jump redirect, sequences a fixed multi-cycle flush.
- Drains the pipeline before FENCE/SYSTEM instructions are issued.

Parameters:
- MAX_OUT, 4, maximum number of issued register writers not yet written back (1..15).
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode outputs hold a valid instruction.
- dec_rs1  in  5  source register 1 index.
- dec_rs1en  in  1  rs1 is read.
- dec_rs2  in  5  source register 2 index.
- dec_rs2en  in  1  rs2 is read.
- dec_rd  in  5  destination register index.
- dec_rden  in  1  rd is written.
- dec_serial  in  1  instruction is MISCMEM or SYSTEM; requires an empty pipeline.
- redirect  in  1  one-cycle pulse from execute: taken branch, JAL or JALR.
- wb_en  in  1  writeback of wb_rd this cycle.
- wb_rd  in  5  writeback register index.
- issue  out  1  instruction issues this cycle (combinational).
- stall  out  1  hold fetch/decode (combinational).
- flush  out  1  squash decode/fetch contents (registered).
- sb_pending  out  32  scoreboard bitmap (registered); bit 0 is always 0.
- out_cnt  out  4  outstanding writer count (registered).

Behaviour:
- Reset (asynchronous): state=RUN, sb_pending=0, out_cnt=0, flush=0, flush counter=0.
  - issue=0 and stall=0 while reset is held.
- Writeback mask: wbm = (wb_en && wb_rd!=0) ? onehot(wb_rd) : 0.
- Effective pending: eff = sb_pending & ~wbm. A same-cycle writeback clears the hazard, so there is no extra bubble.
- Hazard, valid in RUN only: haz = (rs1en && rs1!=0 && eff[rs1]) || (rs2en && rs2!=0 && eff[rs2]) || (rden && rd!=0 && eff[rd]).
- Capacity: cap_ok = (out_cnt - wb_dec) < MAX_OUT, where wb_dec = (wbm!=0).
- Issue condition: issue = dec_valid && state==RUN && !redirect && !haz && cap_ok && !(dec_serial && (out_cnt - wb_dec)!=0).
- Stall condition: stall = dec_valid && !issue && !redirect && state!=FLUSH.
- Scoreboard update at the clock edge: next = (sb_pending & ~wbm) | (issue && rden && rd!=0 ? onehot(rd) : 0).
  - If issue and writeback target the same rd in one cycle, the set wins.
- out_cnt update: +1 on an issued writer, -1 on a writeback, unchanged if both occur.
  - Writeback at out_cnt=0 is a protocol error; out_cnt saturates at 0.
- States:
  - RUN: redirect -> FLUSH (load counter with FLUSH_CYCLES, flush<=1). dec_valid && dec_serial && pending writers -> DRAIN.
  - DRAIN: issue=0, stall=1 while dec_valid. redirect -> FLUSH. out_cnt reaching 0 (registered) -> RUN; the serial instruction issues in the following cycle.
  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles; issue=0 and stall=0. redirect during FLUSH reloads the counter. Counter reaching 1 -> RUN, with flush<=0 at that edge.
- Redirect has priority over every other event in the same cycle; the instruction in decode is not issued.
- Writebacks continue to update sb_pending and out_cnt in all states. Instructions issued before a redirect always complete.
- Reset mid-flush or mid-drain returns to RUN with an empty scoreboard on the next edge after release.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encodings RUN=2'd0, DRAIN=2'd1, FLUSH=2'd2;
  - the opcode constants already used by decode, for the generation of dec_serial.
- One natural sub-module: sb_bitmap (32-bit set/clear register file with x0 hardwired to 0, plus the hazard lookup).
- The FSM and counters stay in the top level.

Test Plan:
- RAW: issue rd=5; next cycle rs1=5 -> stall=1, issue=0. wb_en, wb_rd=5 in the same cycle as the check -> issue=1 that cycle, sb_pending[5] ends at 0.
- x0: rd=0 and rs1=0 repeatedly -> never stalls; sb_pending stays 0 and out_cnt stays 0.
- Capacity (MAX_OUT=4): issue writers to x1..x4 with no writeback; fifth writer x6 -> stall. A wb of x1 in that cycle -> issue=1, out_cnt stays 4.
- Redirect: pulse redirect while dec_valid -> issue=0 that cycle, then flush=1 for exactly 2 cycles then 0. A second redirect in the first flush cycle extends flush to 3 cycles total.
- Serial drain: out_cnt=2, then a FENCE (dec_serial=1) -> state DRAIN, stall=1. After two writebacks out_cnt=0, and the FENCE issues one cycle later.
- Async reset during FLUSH with sb_pending=0x0000_0024 -> immediately flush=0, sb_pending=0, out_cnt=0; RUN after release.
